// File: rtl/crypto_wallet_rng_arbiter.sv
// crypto_wallet_rng_arbiter
// Samples the raw 32-bit RNG word on a programmable divider and applies a
// repetition health check. Accepted words go into a small FIFO. Each word is
// handed to exactly one of two hardware requesters by round-robin arbitration.
// An Avalon-MM slave exposes CTRL / STATUS / DIV to software.
// Optional build macro CRYPTO_WALLET_RNG_WHITEN_EN: when defined, each pushed
// word is the raw sample XOR rotl7(previously pushed word).
//
// Requester handshake: req[i] is a level request. gnt[i] is a one-cycle pulse.
// rnd_data carries the delivered word only in the cycle where gnt[i] is high,
// and is 0 otherwise. A requester whose grant is high in the current cycle is
// not eligible in that cycle, so keeping req high yields at most one word
// every other cycle for that requester. The FIFO pop is committed on the same
// edge that registers the grant.
module crypto_wallet_rng_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rng_in,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [31:0] rnd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  // Control / status registers
  logic          r_en;
  logic [15:0]   r_div;
  logic [15:0]   r_div_cnt;
  logic          r_health_fail;
  logic          r_overflow;
  logic [RW-1:0] r_rep_cnt;
  logic [31:0]   r_prev;
  logic [31:0]   r_readdata;

  // FIFO
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Arbiter
  logic [1:0]    r_gnt;
  logic [31:0]   r_rnd;
  logic          r_last;

  // Combinational decode
  logic          w_wr_ctrl;
  logic          w_wr_div;
  logic          w_flush;
  logic          w_clr_fail;
  logic          w_active;
  logic [15:0]   w_div_eff;
  logic          w_term;
  logic          w_sample;
  logic          w_same;
  logic [RW-1:0] w_rep_next;
  logic          w_fail_set;
  logic          w_push_req;
  logic          w_full;
  logic          w_push_do;
  logic          w_ovf_set;
  logic [1:0]    w_elig;
  logic          w_decide;
  logic          w_win;
  logic [31:0]   w_push_word;
  logic          w_unused;

  assign w_wr_ctrl  = write && (address == 2'd0);
  assign w_wr_div   = write && (address == 2'd2);
  assign w_flush    = w_wr_ctrl && writedata[1];
  assign w_clr_fail = w_wr_ctrl && writedata[2];
  assign w_unused   = ^writedata[31:16];

  // A DIV of 0 is treated as 1 (sample every cycle).
  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_active   = r_en && !r_health_fail;
  // >= keeps the divider from running away if DIV shrinks mid-count.
  assign w_term     = (r_div_cnt >= (w_div_eff - 16'd1));
  assign w_sample   = w_active && w_term;

  assign w_same     = (rng_in == r_prev);
  assign w_rep_next = w_same ? (r_rep_cnt + RW'(1)) : RW'(1);
  assign w_fail_set = w_sample && (w_rep_next >= RW'(REP_LIMIT));
  assign w_push_req = w_sample && !w_same && !w_fail_set;

  // Arbitration: eligible = requesting and not being granted right now.
  assign w_elig     = req & ~r_gnt;
  assign w_decide   = (r_count != '0) && !r_health_fail && (|w_elig)
                      && !w_flush && !w_fail_set;
  // On a tie the requester not granted last wins.
  assign w_win      = (&w_elig) ? ~r_last : w_elig[1];

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_push_do  = w_push_req && !w_flush && (!w_full || w_decide);
  assign w_ovf_set  = w_push_req && !w_flush && w_full && !w_decide;

`ifdef CRYPTO_WALLET_RNG_WHITEN_EN
  logic [31:0] r_wprev;

  assign w_push_word = rng_in ^ {r_wprev[24:0], r_wprev[31:25]};

  // Whitening chain: remember the last word actually written into the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wprev <= '0;
    end else if (w_flush) begin
      r_wprev <= '0;
    end else if (w_push_do) begin
      r_wprev <= w_push_word;
    end
  end
`else
  assign w_push_word = rng_in;
`endif

  // Software-writable control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en  <= 1'b0;
      r_div <= 16'(SAMPLE_DIV);
    end else begin
      if (w_wr_ctrl) r_en  <= writedata[0];
      if (w_wr_div)  r_div <= writedata[15:0];
    end
  end

  // Sample divider, repetition counter and sticky health/overflow flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt     <= '0;
      r_prev        <= '0;
      r_rep_cnt     <= '0;
      r_health_fail <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (!w_active || w_term) r_div_cnt <= '0;
      else                     r_div_cnt <= r_div_cnt + 16'd1;

      if (w_sample) r_prev <= rng_in;

      if (w_clr_fail)    r_rep_cnt <= '0;
      else if (w_sample) r_rep_cnt <= w_rep_next;

      if (w_fail_set)      r_health_fail <= 1'b1;
      else if (w_clr_fail) r_health_fail <= 1'b0;

      if (w_flush)        r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push_do) r_mem[r_wr_ptr] <= w_push_word;
  end

  // FIFO pointers and fill count; flush or health trip empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush || w_fail_set) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_do) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_decide)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_do) - CW'(w_decide);
    end
  end

  // Registered grant pulse and delivered word; pop happens on this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt  <= 2'b00;
      r_rnd  <= '0;
      r_last <= 1'b1;
    end else if (w_decide) begin
      r_gnt  <= w_win ? 2'b10 : 2'b01;
      r_rnd  <= r_mem[r_rd_ptr];
      r_last <= w_win;
    end else begin
      r_gnt  <= 2'b00;
      r_rnd  <= '0;
    end
  end

  // Read mux, registered every cycle (1-cycle latency, no read strobe).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        2'd0:    r_readdata <= {31'd0, r_en};
        2'd1:    r_readdata <= {22'd0, r_overflow, r_health_fail, 8'(r_count)};
        2'd2:    r_readdata <= {16'd0, r_div};
        default: r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign gnt      = r_gnt;
  assign rnd_data = r_rnd;

endmodule

// File: tb/tb_crypto_wallet_rng_arbiter.sv
// Testbench for crypto_wallet_rng_arbiter.
// Stimulus tasks push expected grants and register reads into queues; a
// monitor on the falling clock edge pops and compares when the DUT presents
// a grant or a read result. Honours CRYPTO_WALLET_RNG_WHITEN_EN if defined.
module tb_crypto_wallet_rng_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] rng_in;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [31:0] rnd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] exp_q[$];   // {gnt, rnd_data}
  logic [31:0] rd_q[$];    // expected readdata
  logic [31:0] mdl_q[$];   // model of FIFO contents (post-whitening)
  logic [31:0] m_wprev = '0;
  logic        rd_pend;
  logic        inc_on;

  crypto_wallet_rng_arbiter #(
    .FIFO_DEPTH(8), .SAMPLE_DIV(4), .REP_LIMIT(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rng_in(rng_in), .address(address),
    .write(write), .writedata(writedata), .readdata(readdata),
    .req(req), .gnt(gnt), .rnd_data(rnd_data)
  );

  // Clock and free-running incrementing source
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (inc_on) rng_in = rng_in + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wh(input logic [31:0] raw);
`ifdef CRYPTO_WALLET_RNG_WHITEN_EN
    logic [31:0] w;
    w = raw ^ {m_wprev[24:0], m_wprev[31:25]};
    m_wprev = w;
    return w;
`else
    return raw;
`endif
  endfunction

  // Monitor: compares read results and grants against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (rd_q.size() == 0) chk("rd_q_nonempty", 64'(rd_q.size()), 64'd1);
        else chk("readdata", 64'(readdata), 64'(rd_q.pop_front()));
      end
      if (gnt !== 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", {30'd0, gnt, rnd_data}, 64'd0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("gnt", 64'(gnt), 64'(e[33:32]));
          chk("rnd_data", 64'(rnd_data), 64'(e[31:0]));
        end
      end else begin
        chk("rnd_data_idle", 64'(rnd_data), 64'd0);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    address = a;
    rd_q.push_back(e);
    @(posedge clk); #1;
    rd_pend = 1'b1;
    @(posedge clk); #1;
    rd_pend = 1'b0;
  endtask

  // Enable sampling (DIV must be 0/1) for exactly n samples base + i*step.
  task automatic load(input logic [31:0] base, input logic [31:0] step, input int n);
    address = 2'd0; writedata = 32'd1; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    for (int i = 0; i < n; i++) begin
      rng_in = base + step * 32'(i);
      mdl_q.push_back(wh(rng_in));
      if (i == n - 1) begin
        write = 1'b1; writedata = 32'd0;
      end
      @(posedge clk); #1;
    end
    write = 1'b0;
  endtask

  task automatic exp_gnt(input logic [1:0] g);
    if (mdl_q.size() > 0) exp_q.push_back({g, mdl_q.pop_front()});
  endtask

  // Main stimulus
  initial begin
    reset_n = 1'b0; rng_in = '0; address = '0; write = 1'b0; writedata = '0;
    req = 2'b00; rd_pend = 1'b0; inc_on = 1'b0;
    tick(3);
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rnd", 64'(rnd_data), 64'd0);
    chk("reset_readdata", 64'(readdata), 64'd0);
    reset_n = 1'b1;
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h4);

    // Overflow with no requesters, then FLUSH
    wr(2'd2, 32'd1);
    rng_in = 32'h100;
    inc_on = 1'b1;
    wr(2'd0, 32'd1);
    rd(2'd0, 32'h1);
    tick(20);
    wr(2'd0, 32'd0);
    inc_on = 1'b0;
    rd(2'd1, 32'h208);
    wr(2'd0, 32'd2);
    m_wprev = '0;
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h0);

    // Round-robin with both requesting
    load(32'hA000_0001, 32'h10, 3);
    rd(2'd1, 32'h3);
    exp_gnt(2'b01); exp_gnt(2'b10); exp_gnt(2'b01);
    req = 2'b11;
    tick(6);
    req = 2'b00;
    chk("rr_drained", 64'(exp_q.size()), 64'd0);
    rd(2'd1, 32'h0);

    // Repetition health failure
    load(32'hB000_0000, 32'h1, 2);
    rd(2'd1, 32'h2);
    rng_in = 32'hDEAD_BEEF;
    wr(2'd0, 32'd1);
    tick(8);
    mdl_q.delete();
    void'(wh(32'hDEAD_BEEF));
    rd(2'd1, 32'h100);
    req = 2'b11;
    tick(4);
    req = 2'b00;
    rd(2'd0, 32'h1);
    wr(2'd0, 32'd4);
    rd(2'd1, 32'h0);
    load(32'hC000_0000, 32'h1, 2);
    rd(2'd1, 32'h2);
    exp_gnt(2'b01); exp_gnt(2'b01);
    req = 2'b01;
    tick(6);
    req = 2'b00;
    chk("single_drained", 64'(exp_q.size()), 64'd0);

    // Full FIFO: push and pop coincide
    load(32'hD000_0000, 32'h11, 8);
    rd(2'd1, 32'h8);
    exp_gnt(2'b01);
    mdl_q.push_back(wh(32'hE000_0000));
    address = 2'd0; writedata = 32'd1; write = 1'b1; rng_in = 32'hE000_0000;
    @(posedge clk); #1;
    writedata = 32'd0; req = 2'b01;
    @(posedge clk); #1;
    write = 1'b0; req = 2'b00;
    rd(2'd1, 32'h8);
    exp_gnt(2'b10); exp_gnt(2'b01); exp_gnt(2'b10); exp_gnt(2'b01);
    exp_gnt(2'b10); exp_gnt(2'b01); exp_gnt(2'b10); exp_gnt(2'b01);
    req = 2'b11;
    tick(12);
    req = 2'b00;
    chk("full_drained", 64'(exp_q.size()), 64'd0);
    rd(2'd1, 32'h0);

    // Asynchronous reset mid-operation
    load(32'hF000_0000, 32'h1, 3);
    mdl_q.delete();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_gnt", 64'(gnt), 64'd0);
    chk("async_rst_readdata", 64'(readdata), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_wprev = '0;
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h4);
    rd(2'd0, 32'h0);

    // DIV=0 behaves as 1; whitening of 0x1 then 0x2
    wr(2'd2, 32'd0);
    rd(2'd2, 32'h0);
    load(32'h1, 32'h1, 2);
    mdl_q.delete();
    exp_q.push_back({2'b01, 32'h0000_0001});
`ifdef CRYPTO_WALLET_RNG_WHITEN_EN
    exp_q.push_back({2'b01, 32'h0000_0082});
`else
    exp_q.push_back({2'b01, 32'h0000_0002});
`endif
    req = 2'b01;
    tick(6);
    req = 2'b00;
    chk("whiten_drained", 64'(exp_q.size()), 64'd0);

    tick(2);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
